// File: rtl/sum_result_buffer.sv
// Purpose: circular buffer of adder results, each tagged with its signed-overflow flag.
// Latency: a push is visible at the head one cycle later, with no same-cycle bypass.
// Backpressure: o_ready = !o_full from registered state only; i_valid while full is ignored.
module sum_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_a_msb,
  input  logic             i_b_msb,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf_sticky,
  input  logic             i_clr_sticky
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_sum [DEPTH];
  logic             mem_ovf [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             sticky;
  logic             push;
  logic             pop;
  logic             ovf_in;

  // Occupancy flags, handshakes and the incoming overflow classification.
  always_comb begin
    o_full  = (count == FULL_CNT);
    o_empty = (count == '0);
    o_ready = !o_full;
    o_valid = !o_empty;
    push    = i_valid && o_ready;
    pop     = o_valid && i_ready;
    // Same-sign operands whose sum changes sign have overflowed.
    ovf_in  = (i_a_msb == i_b_msb) && (i_sum[WIDTH-1] != i_a_msb);
  end

  // Head entry is forced to zero when the buffer holds nothing.
  always_comb begin
    o_sum = '0;
    o_ovf = 1'b0;
    if (!o_empty) begin
      o_sum = mem_sum[rd_ptr];
      o_ovf = mem_ovf[rd_ptr];
    end
  end

  assign o_count      = count;
  assign o_ovf_sticky = sticky;

  // Entry storage needs no reset: stale contents are never visible past the empty gate.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_sum[wr_ptr] <= i_sum;
      mem_ovf[wr_ptr] <= ovf_in;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a same-cycle set takes priority over the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky <= 1'b0;
    end else if (push && ovf_in) begin
      sticky <= 1'b1;
    end else if (i_clr_sticky) begin
      sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_result_buffer.sv
// Directed bench for sum_result_buffer (WIDTH 32, DEPTH 4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// All expected values are hand-computed constants or loop-derived sequences.
module tb_sum_result_buffer;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_sum;
  logic        i_a_msb;
  logic        i_b_msb;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_ovf;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_empty;
  logic        o_ovf_sticky;
  logic        i_clr_sticky;

  int checks = 0;
  int errors = 0;

  sum_result_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_sum        (i_sum),
    .i_a_msb      (i_a_msb),
    .i_b_msb      (i_b_msb),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sum        (o_sum),
    .o_ovf        (o_ovf),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_ovf_sticky (o_ovf_sticky),
    .i_clr_sticky (i_clr_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_sum = '0; i_a_msb = 1'b0; i_b_msb = 1'b0;
    i_ready = 1'b0; i_clr_sticky = 1'b0;
    #1 i_rst = 1'b1;
    #2;
    // Reset state, before any clock edge
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_sum", o_sum, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_sticky", o_ovf_sticky, 0);

    // Single push on the first edge after release
    @(negedge i_clk);
    i_rst = 1'b0;
    i_valid = 1'b1; i_sum = 32'h0000_0005; i_a_msb = 1'b0; i_b_msb = 1'b0; i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    chk("single_valid", o_valid, 1);
    chk("single_sum", o_sum, 32'h5);
    chk("single_ovf", o_ovf, 0);
    chk("single_count", o_count, 1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("single_drained", o_empty, 1);

    // Fill to full, then an ignored fifth push
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_sum = 32'(k);
      tick();
    end
    chk("fill_full", o_full, 1);
    chk("fill_ready", o_ready, 0);
    chk("fill_count", o_count, 4);
    i_sum = 32'h5;
    tick();
    i_valid = 1'b0;
    chk("blocked_count", o_count, 4);
    chk("blocked_head", o_sum, 32'h1);

    // Drain in order
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", o_valid, 1);
      chk("drain_sum", o_sum, 32'(k));
      tick();
      if (k == 1) begin
        chk("unfull_count", o_count, 3);
        chk("unfull_ready", o_ready, 1);
      end
    end
    i_ready = 1'b0;
    chk("drain_empty", o_empty, 1);
    chk("drain_sum_zero", o_sum, 0);

    // Overflow flagging and sticky set-wins
    i_valid = 1'b1; i_sum = 32'h8000_0000; i_a_msb = 1'b0; i_b_msb = 1'b0;
    tick();
    chk("ovf_flag", o_ovf, 1);
    chk("ovf_sticky", o_ovf_sticky, 1);
    i_sum = 32'h7FFF_FFFF; i_a_msb = 1'b1; i_b_msb = 1'b1; i_clr_sticky = 1'b1;
    tick();
    i_valid = 1'b0; i_clr_sticky = 1'b0;
    chk("set_wins_sticky", o_ovf_sticky, 1);
    chk("set_wins_count", o_count, 2);
    i_ready = 1'b1;
    tick();
    chk("neg_ovf_sum", o_sum, 32'h7FFF_FFFF);
    chk("neg_ovf_flag", o_ovf, 1);
    tick();
    i_ready = 1'b0;
    chk("ovf_drained", o_empty, 1);
    i_clr_sticky = 1'b1;
    tick();
    i_clr_sticky = 1'b0;
    chk("clr_sticky", o_ovf_sticky, 0);
    i_valid = 1'b1; i_sum = 32'h8000_0001; i_a_msb = 1'b1; i_b_msb = 1'b0;
    tick();
    i_valid = 1'b0;
    chk("mixed_sign_ovf", o_ovf, 0);
    chk("mixed_sign_sticky", o_ovf_sticky, 0);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("mixed_drained", o_empty, 1);

    // Wrap-around: pre-load then continuous push/pop
    i_a_msb = 1'b0; i_b_msb = 1'b0;
    i_valid = 1'b1; i_sum = 32'd100;
    tick();
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_sum = 32'(101 + k);
      chk("wrap_head", o_sum, 32'(100 + k));
      tick();
      chk("wrap_count", o_count, 1);
    end
    i_valid = 1'b0;
    chk("wrap_last", o_sum, 32'd110);
    tick();
    i_ready = 1'b0;
    chk("wrap_drained", o_empty, 1);

    // Reset mid-operation, asserted between edges
    for (int k = 1; k <= 3; k++) begin
      i_valid = 1'b1; i_sum = 32'(k * 17);
      tick();
    end
    i_valid = 1'b0;
    chk("pre_rst_count", o_count, 3);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_sum", o_sum, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_valid = 1'b1; i_sum = 32'hA;
    tick();
    i_valid = 1'b0;
    chk("post_rst_sum", o_sum, 32'hA);
    chk("post_rst_count", o_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_result_buffer.md
SUM_RESULT_BUFFER -- requirements
Module: sum_result_buffer

Interface
REQ-001 Parameter WIDTH, default 32, is the sum data width.
REQ-002 Parameter DEPTH, default 4, is the number of buffer entries; it SHALL be a power of two, at least 2.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_valid  input  1  upstream adder result valid.
REQ-006 i_sum  input  WIDTH  sum from the 32-bit adder.
REQ-007 i_a_msb  input  1  MSB of operand A that produced i_sum.
REQ-008 i_b_msb  input  1  MSB of operand B that produced i_sum.
REQ-009 o_ready  output  1  buffer can accept a result this cycle.
REQ-010 o_valid  output  1  head entry available.
REQ-011 i_ready  input  1  downstream accepts the head entry.
REQ-012 o_sum  output  WIDTH  head entry sum.
REQ-013 o_ovf  output  1  head entry signed-overflow flag.
REQ-014 o_count  output  log2(DEPTH)+1  number of occupied entries.
REQ-015 o_full, o_empty  output  1 each  occupancy flags.
REQ-016 o_ovf_sticky  output  1  set when any overflowing result has been accepted since the last clear.
REQ-017 i_clr_sticky  input  1  synchronous clear of o_ovf_sticky.

Function
REQ-018 Push SHALL occur on a rising edge when i_valid and o_ready are both 1; pop SHALL occur when o_valid and i_ready are both 1.
REQ-019 Each pushed entry SHALL store i_sum and ovf = (i_a_msb == i_b_msb) and (i_sum[WIDTH-1] != i_a_msb).
REQ-020 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0 with no gap.
REQ-021 o_ready SHALL be the inverse of o_full, derived from registered state only, with no combinational path from i_ready.
REQ-022 o_valid SHALL be the inverse of o_empty.
REQ-023 o_sum and o_ovf SHALL show the entry at the read pointer when not empty, and SHALL be 0 when empty.
REQ-024 Latency: an entry pushed into an empty buffer SHALL appear on o_valid/o_sum on the next cycle, with no same-cycle bypass.
REQ-025 Simultaneous push and pop when neither full nor empty: o_count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full: push is blocked (o_ready = 0), and a pop SHALL reduce o_count to DEPTH-1, with o_ready = 1 on the next cycle.
REQ-027 When empty: pop is impossible (o_valid = 0), and a push SHALL raise o_count to 1.
REQ-028 i_valid while o_ready = 0 SHALL be ignored with no state change, and upstream SHALL hold its data.
REQ-029 o_ovf_sticky SHALL set on any push whose ovf = 1 and SHALL clear on i_clr_sticky.
REQ-030 If a set event and i_clr_sticky occur in the same cycle, set SHALL win.
REQ-031 o_count SHALL satisfy 0 <= o_count <= DEPTH at all times.
REQ-032 o_full SHALL equal (o_count == DEPTH) and o_empty SHALL equal (o_count == 0).

Reset
REQ-033 While i_rst = 1, regardless of clock, the block SHALL hold:
  - pointers = 0, o_count = 0, o_empty = 1, o_full = 0
  - o_valid = 0, o_ready = 1, o_sum = 0, o_ovf = 0, o_ovf_sticky = 0
REQ-034 Reset asserted mid-operation SHALL discard all stored entries.
REQ-035 The first push SHALL be accepted on the first rising edge after i_rst deasserts.

Verification
REQ-036 Single push, DEPTH = 4: push i_sum = 0x0000_0005 (msbs 0, 0) with i_ready = 0 -> next cycle o_valid = 1, o_sum = 0x0000_0005, o_ovf = 0, o_count = 1.
REQ-037 Fill then drain: push 0x1, 0x2, 0x3, 0x4 with i_ready = 0 -> o_full = 1, o_ready = 0, and a 5th push value 0x5 is ignored. Then drain with i_ready = 1 -> outputs 0x1, 0x2, 0x3, 0x4 in order, then o_empty = 1 and o_sum = 0.
REQ-038 Overflow flagging:
  - push 0x8000_0000 (a_msb = 0, b_msb = 0) -> o_ovf = 1, o_ovf_sticky = 1
  - then pulse i_clr_sticky together with pushing 0x7FFF_FFFF (a_msb = 1, b_msb = 1) -> o_ovf_sticky stays 1 (set wins)
REQ-039 Wrap-around: run 10 cycles of continuous push and pop with i_valid = 1 and i_ready = 1 after one pre-load -> o_count stays 1, data order is preserved across the pointer wrap, and there is no loss.
REQ-040 Reset mid-operation: with 3 entries held, assert i_rst asynchronously between clock edges -> o_count = 0, o_valid = 0 immediately. After release, push 0xA -> o_sum = 0xA next cycle.
